ram_port_arbiter: RTL and testbench

- Shares the single-port 32-bit block RAM (Gowin_SP) between two requesters: the CPU core (fetch, load, store) and the video/DMA port (framebuffer scan and CHIP-8 sprite copy).
- Sits between the requesters and the RAM primitive, so neither requester drives the RAM directly.
- Arbitrates round-robin and sequences each transaction against the RAM's one-cycle synchronous read.
- Performs partial (byte-lane) writes as an atomic read-modify-write, so the core no longer merges bytes itself.

---
 rtl/ram_arb_pkg.sv | 31 +++
 rtl/ram_byte_merge.sv | 31 +++
 rtl/ram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and constants for the block-RAM port arbiter.
//            Holds the sequencer state encoding, the requester identifiers
//            and the two byte-strobe patterns that pick the write class.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  // Sequencer states: IDLE arbitrates, ISSUE drives the RAM, RESP consumes
  // the read data one cycle later (read return or merged write-back).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VID = 1'b1
  } req_id_e;

  localparam logic [3:0] STRB_FULL = 4'b1111;
  localparam logic [3:0] STRB_NONE = 4'b0000;

endpackage

`default_nettype wire

// File: rtl/ram_byte_merge.sv
// ============================================================================
// Module   : ram_byte_merge
// Purpose  : Combinational byte-lane merge for read-modify-write. Each byte
//            lane takes the new data when its strobe is set, otherwise keeps
//            the word currently stored in the RAM.
// Ports    : old_i    - word read back from the RAM
//            new_i    - lane-aligned write data
//            strb_i   - byte enables, bit n covers bits [8n+7:8n]
//            merged_o - resulting word to write back
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_byte_merge
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   new_i,
  input  logic [DATA_W/8-1:0] strb_i,
  output logic [DATA_W-1:0]   merged_o
);

  for (genvar n = 0; n < DATA_W / 8; n++) begin : g_lane
    assign merged_o[8*n +: 8] = strb_i[n] ? new_i[8*n +: 8] : old_i[8*n +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one single-port synchronous-read block RAM between the
//            CPU and the video/DMA requester. Round-robin arbitration in
//            IDLE, then a short sequence per command: full writes go straight
//            out, reads return data one cycle after issue, and partial writes
//            become an atomic read-modify-write.
// Ports    : sys_clk, sys_rst        - clock, async active-high reset
//            cpu_req/we/addr/wdata/wstrb -> cpu_gnt/rvalid/rdata
//            vid_req/we/addr/wdata/wstrb -> vid_gnt/rvalid/rdata
//            ram_ce/wre/ad/din       - RAM command outputs
//            ram_dout                - RAM read data (one cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Video / DMA requester
  input  logic              vid_req,
  input  logic              vid_we,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [DATA_W-1:0] vid_wdata,
  input  logic [3:0]        vid_wstrb,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  // RAM primitive
  output logic              ram_ce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_e        state_q;
  req_id_e           owner_q;
  req_id_e           last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vid_rdata_q;

  logic              w_pick_vid;
  logic              w_grant;
  logic              w_is_read;
  logic              w_is_full;
  logic              w_is_none;
  logic              w_is_part;
  logic [DATA_W-1:0] w_merged;

  // Video wins when it is the only requester, or on a tie when the CPU was
  // served last. Everything else (including a tie after reset) goes to CPU.
  assign w_pick_vid = vid_req && (!cpu_req || (last_q == REQ_CPU));
  assign w_grant    = (state_q == IDLE) && (cpu_req || vid_req);

  // Reset gating keeps the combinational grants at their reset value while
  // reset is held, without feeding the reset into the synchronous logic.
  assign cpu_gnt = w_grant && !w_pick_vid && !sys_rst;
  assign vid_gnt = w_grant &&  w_pick_vid && !sys_rst;

  // Command class of the latched transaction.
  assign w_is_read = !we_q;
  assign w_is_full = we_q && (wstrb_q == STRB_FULL);
  assign w_is_none = we_q && (wstrb_q == STRB_NONE);
  assign w_is_part = we_q && !w_is_full && !w_is_none;

  ram_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_i    (ram_dout),
    .new_i    (wdata_q),
    .strb_i   (wstrb_q),
    .merged_o (w_merged)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      owner_q     <= REQ_CPU;
      last_q      <= REQ_VID;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= STRB_NONE;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_grant) begin
            owner_q <= w_pick_vid ? REQ_VID : REQ_CPU;
            last_q  <= w_pick_vid ? REQ_VID : REQ_CPU;
            we_q    <= w_pick_vid ? vid_we    : cpu_we;
            addr_q  <= w_pick_vid ? vid_addr  : cpu_addr;
            wdata_q <= w_pick_vid ? vid_wdata : cpu_wdata;
            wstrb_q <= w_pick_vid ? vid_wstrb : cpu_wstrb;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Reads and partial writes need the RAM word back next cycle.
          state_q <= (w_is_full || w_is_none) ? IDLE : RESP;
        end
        RESP: begin
          if (w_is_read) begin
            if (owner_q == REQ_CPU) cpu_rdata_q <= ram_dout;
            else                    vid_rdata_q <= ram_dout;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM command is decoded from the state so that an asynchronous reset
  // drops ram_wre immediately and the merged write-back can use ram_dout
  // in the same cycle it becomes valid.
  assign ram_ce  = ((state_q == ISSUE) && !w_is_none) || ((state_q == RESP) && w_is_part);
  assign ram_wre = ((state_q == ISSUE) &&  w_is_full) || ((state_q == RESP) && w_is_part);
  assign ram_ad  = addr_q;
  assign ram_din = (state_q == RESP) ? w_merged : wdata_q;

  // Read return: pulse to the owner only, with the RAM data bypassed so it
  // is visible in the pulse cycle and held in the register afterwards.
  assign cpu_rvalid = (state_q == RESP) && w_is_read && (owner_q == REQ_CPU);
  assign vid_rvalid = (state_q == RESP) && w_is_read && (owner_q == REQ_VID);
  assign cpu_rdata  = cpu_rvalid ? ram_dout : cpu_rdata_q;
  assign vid_rdata  = vid_rvalid ? ram_dout : vid_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter with a behavioural
//            single-port synchronous-read RAM attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  typedef struct {
    int          p;      // 0 = CPU, 1 = VID
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;    // read data, or RAM din for a write
  } vec_t;

  typedef struct {
    int          p;
    logic [31:0] data;
    logic [12:0] addr;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        sys_rst;
  logic        cpu_req, cpu_we, vid_req, vid_we;
  logic [12:0] cpu_addr, vid_addr;
  logic [31:0] cpu_wdata, vid_wdata;
  logic [3:0]  cpu_wstrb, vid_wstrb;
  logic        cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid;
  logic [31:0] cpu_rdata, vid_rdata;
  logic        ram_ce, ram_wre;
  logic [12:0] ram_ad;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:8191] = '{default: 32'h0};

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   next_free = 0;
  logic [31:0] last_rd [2];
  exp_t rd_q[$];
  exp_t wr_q[$];
  int   gnt_log[$];
  int   gnt_cyc[$];

  ram_port_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
    .sys_clk   (clk),       .sys_rst   (sys_rst),
    .cpu_req   (cpu_req),   .cpu_we    (cpu_we),    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata), .cpu_wstrb (cpu_wstrb), .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),.cpu_rdata (cpu_rdata),
    .vid_req   (vid_req),   .vid_we    (vid_we),    .vid_addr  (vid_addr),
    .vid_wdata (vid_wdata), .vid_wstrb (vid_wstrb), .vid_gnt   (vid_gnt),
    .vid_rvalid(vid_rvalid),.vid_rdata (vid_rdata),
    .ram_ce    (ram_ce),    .ram_wre   (ram_wre),   .ram_ad    (ram_ad),
    .ram_din   (ram_din),   .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural Gowin_SP: write on wre, otherwise registered read.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         ram_dout    <= mem[ram_ad];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Presents one command on a port (caller is just after a rising edge),
  // waits for its grant, and pushes the expected RAM/read outcome.
  task automatic issue(input vec_t v, output int g);
    if (v.p == 0) begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_wstrb = v.strb;
    end else begin
      vid_req = 1'b1; vid_we = v.we; vid_addr = v.addr; vid_wdata = v.wdata; vid_wstrb = v.strb;
    end
    g = -1;
    for (int k = 0; k < 40 && g < 0; k++) begin
      @(negedge clk);
      if ((v.p == 0 && cpu_gnt) || (v.p == 1 && vid_gnt)) g = cyc;
    end
    n_vec++;
    if (g < 0) begin
      n_bad++;
      $display("FAIL grant_timeout port=%0d actual=no grant required=grant within 40 cycles", v.p);
    end else if (!v.we) begin
      rd_q.push_back('{p: v.p, data: v.exp, addr: v.addr, cyc: g + 2});
    end else if (v.strb == 4'hF) begin
      wr_q.push_back('{p: v.p, data: v.exp, addr: v.addr, cyc: g + 1});
    end else if (v.strb != 4'h0) begin
      wr_q.push_back('{p: v.p, data: v.exp, addr: v.addr, cyc: g + 2});
    end
    @(posedge clk); #1;
    if (v.p == 0) cpu_req = 1'b0;
    else          vid_req = 1'b0;
  endtask

  // Monitor: grant spacing, RAM writes and read returns against the queues.
  initial begin
    logic       w;
    logic [3:0] s;
    int         p;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        next_free  = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
      end else begin
        if (cpu_gnt || vid_gnt) begin
          chk("gnt_exclusive", 32'(cpu_gnt & vid_gnt), 32'd0);
          chk("gnt_while_busy", 32'(cyc < next_free), 32'd0);
          gnt_log.push_back(cpu_gnt ? 0 : 1);
          gnt_cyc.push_back(cyc);
          w = cpu_gnt ? cpu_we : vid_we;
          s = cpu_gnt ? cpu_wstrb : vid_wstrb;
          next_free = cyc + ((!w || (s != 4'hF && s != 4'h0)) ? 3 : 2);
        end
        if (ram_ce && ram_wre) begin
          if (wr_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_write actual=ad %h din %h required=no write", ram_ad, ram_din);
          end else begin
            e = wr_q.pop_front();
            chk("wr_addr",  {19'b0, ram_ad}, {19'b0, e.addr});
            chk("wr_data",  ram_din, e.data);
            chk("wr_cycle", cyc, e.cyc);
          end
        end
        if (cpu_rvalid || vid_rvalid) begin
          chk("rvalid_exclusive", 32'(cpu_rvalid & vid_rvalid), 32'd0);
          p = cpu_rvalid ? 0 : 1;
          if (rd_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_rvalid actual=port %0d required=no rvalid", p);
          end else begin
            e = rd_q.pop_front();
            chk("rd_port",  p, e.p);
            chk("rd_data",  (p == 1) ? vid_rdata : cpu_rdata, e.data);
            chk("rd_cycle", cyc, e.cyc);
            chk("rd_other_hold", (p == 1) ? cpu_rdata : vid_rdata, last_rd[1-p]);
            last_rd[p] = e.data;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [15];
    vec_t av [6];
    vec_t pv, cv;
    int   g, gv, gc;
    int   gaps [6] = '{0, 3, 2, 3, 2, 3};

    tv[0]  = '{0, 1'b1, 13'h0010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
    tv[1]  = '{0, 1'b0, 13'h0010, 32'h0,        4'b0000, 32'hDEADBEEF};
    tv[2]  = '{0, 1'b1, 13'h0020, 32'h11223344, 4'b1111, 32'h11223344};
    tv[3]  = '{0, 1'b1, 13'h0020, 32'h00AA0000, 4'b0100, 32'h11AA3344};
    tv[4]  = '{0, 1'b0, 13'h0020, 32'h0,        4'b0000, 32'h11AA3344};
    tv[5]  = '{1, 1'b1, 13'h1FFF, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
    tv[6]  = '{1, 1'b1, 13'h1FFF, 32'h000000AB, 4'b0001, 32'hCAFEF0AB};
    tv[7]  = '{1, 1'b1, 13'h1FFF, 32'h12000000, 4'b1000, 32'h12FEF0AB};
    tv[8]  = '{0, 1'b0, 13'h1FFF, 32'h0,        4'b0000, 32'h12FEF0AB};
    tv[9]  = '{1, 1'b0, 13'h0010, 32'h0,        4'b0000, 32'hDEADBEEF};
    tv[10] = '{0, 1'b1, 13'h0010, 32'h55000066, 4'b1001, 32'h55ADBE66};
    tv[11] = '{0, 1'b1, 13'h0010, 32'hFFFFFFFF, 4'b0000, 32'h0};
    tv[12] = '{1, 1'b0, 13'h0010, 32'h0,        4'b0000, 32'h55ADBE66};
    tv[13] = '{0, 1'b1, 13'h0000, 32'h00007700, 4'b0010, 32'h00007700};
    tv[14] = '{1, 1'b0, 13'h0000, 32'h0,        4'b0000, 32'h00007700};

    // Contention set: CPU entries at even indices, VID at odd.
    av[0] = '{0, 1'b0, 13'h0010, 32'h0,        4'b0000, 32'h55ADBE66};
    av[1] = '{1, 1'b1, 13'h0030, 32'hA5A5A5A5, 4'b1111, 32'hA5A5A5A5};
    av[2] = '{0, 1'b1, 13'h0030, 32'h00003C00, 4'b0010, 32'hA5A53CA5};
    av[3] = '{1, 1'b1, 13'h0030, 32'h12345678, 4'b0000, 32'h0};
    av[4] = '{0, 1'b0, 13'h0030, 32'h0,        4'b0000, 32'hA5A53CA5};
    av[5] = '{1, 1'b0, 13'h0020, 32'h0,        4'b0000, 32'h11AA3344};

    // Reset with both requests high: grants must stay low.
    sys_rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    vid_req = 1'b1; vid_we = 1'b0; vid_addr = '0; vid_wdata = '0; vid_wstrb = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
    chk("rst_vid_gnt",    32'(vid_gnt),    32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
    chk("rst_cpu_rdata",  cpu_rdata,       32'd0);
    chk("rst_vid_rdata",  vid_rdata,       32'd0);
    chk("rst_ram_ce",     32'(ram_ce),     32'd0);
    chk("rst_ram_wre",    32'(ram_wre),    32'd0);
    chk("rst_ram_ad",     {19'b0, ram_ad}, 32'd0);
    chk("rst_ram_din",    ram_din,         32'd0);
    cpu_req = 1'b0; vid_req = 1'b0;
    @(negedge clk); sys_rst = 1'b0;
    @(posedge clk); #1;

    // Single transactions, one at a time.
    for (int i = 0; i < 15; i++) begin
      issue(tv[i], g);
      repeat (3) @(posedge clk);
      #1;
    end

    // Continuous contention straight after reset: CPU first, strict
    // alternation, each grant exactly one transaction after the previous.
    sys_rst = 1'b1;
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    @(posedge clk); #1;
    gnt_log.delete();
    gnt_cyc.delete();
    fork
      begin
        int gx;
        for (int i = 0; i < 6; i += 2) issue(av[i], gx);
      end
      begin
        int gy;
        for (int i = 1; i < 6; i += 2) issue(av[i], gy);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("arb_grant_count", gnt_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
      chk("arb_order", gnt_log[i], i % 2);
      if (i > 0) chk("arb_gap", gnt_cyc[i] - gnt_cyc[i-1], gaps[i]);
    end

    // VID partial write in flight; CPU asks during it and must wait for the
    // merged write-back, then read the merged word.
    pv = '{1, 1'b1, 13'h0020, 32'h000000EE, 4'b0001, 32'h11AA33EE};
    cv = '{0, 1'b0, 13'h0020, 32'h0,        4'b0000, 32'h11AA33EE};
    fork
      issue(pv, gv);
      begin
        @(posedge clk); #1;
        issue(cv, gc);
      end
    join
    chk("cpu_wait_partwr", gc - gv, 32'd3);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the RESP cycle of a partial write: the write must vanish.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0020;
    cpu_wdata = 32'h0000BBBB; cpu_wstrb = 4'b0011;
    g = -1;
    for (int k = 0; k < 10 && g < 0; k++) begin
      @(negedge clk);
      if (cpu_gnt) g = cyc;
    end
    chk("rmw_rst_grant", 32'(g >= 0), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("rmw_resp_wre", 32'(ram_wre), 32'd1);
    sys_rst = 1'b1;
    #1;
    chk("rmw_rst_wre",       32'(ram_wre),    32'd0);
    chk("rmw_rst_ce",        32'(ram_ce),     32'd0);
    chk("rmw_rst_ad",        {19'b0, ram_ad}, 32'd0);
    chk("rmw_rst_din",       ram_din,         32'd0);
    chk("rmw_rst_cpu_rdata", cpu_rdata,       32'd0);
    chk("rmw_rst_rvalid",    32'(cpu_rvalid | vid_rvalid), 32'd0);
    @(negedge clk); sys_rst = 1'b0;
    @(posedge clk); #1;
    issue(cv, g);
    repeat (3) @(posedge clk);
    #1;

    chk("queues_drained", rd_q.size() + wr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
